sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Write-side engine for the 640x480 palette-index frame buffer; the color mapper reads this buffer and turns each index into RGB.
- Copies a fixed-size sprite from a synchronous sprite ROM into the frame buffer at a given (x,y).
- Skips transparent pixels and clips sprites that run past the right or bottom edge.
- Also clears or fills the whole frame buffer with one palette index.

Parameters:
- FB_W, 640, frame buffer width in pixels
- FB_H, 480, frame buffer height in pixels
- SPR_W, 16, sprite width
- SPR_H, 16, sprite height
- PIX_W, 5, palette index width
- FB_AW, 19, frame buffer address width
- ID_W, 4, sprite id width; ROM address width is ID_W + log2(SPR_W*SPR_H) = 12

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start_blit  in  1  one-cycle request to copy a sprite
- start_fill  in  1  one-cycle request to fill the whole frame
- sprite_id  in  ID_W  sprite to copy; latched on start_blit
- pos_x  in  10  sprite top-left X; latched
- pos_y  in  10  sprite top-left Y; latched
- fill_idx  in  PIX_W  index written by a fill; latched
- rom_addr  out  12  sprite ROM read address
- rom_data  in  PIX_W  ROM data, valid one cycle after rom_addr
- fb_addr  out  FB_AW  frame buffer write address
- fb_data  out  PIX_W  frame buffer write data
- fb_we  out  1  frame buffer write enable, one pixel per cycle
- busy  out  1  high while an operation is running
- done  out  1  one-cycle pulse when an operation completes

Behaviour:
- Reset (async, reset_n=0): state IDLE; fb_we, fb_addr, fb_data, rom_addr, busy and done all 0. A reset during an operation aborts it immediately; no further writes and no done pulse.
- All outputs are registered.
- States: IDLE -> FILL -> DONE -> IDLE, or IDLE -> BLIT -> DRAIN -> DONE -> IDLE.
- IDLE: start_fill has priority over start_blit if both are high. Starts are ignored unless the state is IDLE; no queuing.
- The edge that samples the start is E0; cycle n is the cycle after edge En-1.
- FILL:
  - busy=1 from cycle 1.
  - fb_we=1 in cycles 1..307200, fb_addr = 0..307199, fb_data = fill_idx.
  - done=1 in cycle 307201 only; busy=0 from that cycle.
- BLIT:
  - busy=1 from cycle 1.
  - Raster counters sx (0..SPR_W-1, inner) and sy (outer).
  - Pixel p = sy*SPR_W + sx is addressed in cycle 1+p, with rom_addr = sprite_id*SPR_W*SPR_H + p.
  - Its write appears in cycle 3+p: fb_addr = (pos_y+sy)*FB_W + (pos_x+sx), computed at 19 bits with no truncation before the compare.
  - fb_we for pixel p is high only if rom_data != 0 (index 0 is transparent) AND pos_x+sx < FB_W AND pos_y+sy < FB_H. Otherwise fb_we=0 and fb_addr/fb_data hold their previous values.
  - DRAIN covers the 2 pipeline cycles after the last ROM address.
  - done=1 in cycle 3+SPR_W*SPR_H = 259; busy=0 from that cycle.
- Clip arithmetic uses 11-bit sums, so pos_x=1023 with sx=15 does not wrap.
- Pixel rate is one per clock; there is no backpressure from the frame buffer.
- DONE lasts exactly one cycle. A start in the DONE cycle is ignored; a start in the next cycle (IDLE) is accepted.

Decomposition:
- Package fb_pkg holds:
  - constants FB_W, FB_H, PIX_W, FB_AW, TRANSPARENT_IDX = 5'd0
  - typedef pix_t, logic [PIX_W-1:0]
  - typedef fb_addr_t, logic [FB_AW-1:0]
  - enum blit_state_t {IDLE, FILL, BLIT, DRAIN, DONE}
- Sub-module fb_addr_calc: combinational; takes x,y (11 bit) and returns fb_addr_t plus an in_bounds flag. The color mapper can reuse it.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0; release reset_n -> remain 0 until a start.
- Fill: start_fill, fill_idx=3 -> 307200 consecutive writes, first addr 0, last 307199, all data 3; done in cycle 307201, exactly one pulse.
- Blit: sprite 2 all-nonzero at (100,50) -> 256 writes; first addr 32100 in cycle 3; pixel p=17 at addr 32741 (51*640+101); rom_addr starts at 512; done in cycle 259.
- Transparency: sprite whose even pixels are 0 -> exactly 128 writes, none at even p, done still in cycle 259.
- Clipping: blit at (630,470) -> writes only sx 0..9, sy 0..9 (100 writes), max addr 479*640+639 = 307199. Blit at (1023,0) -> zero writes, done in cycle 259.
- Conflicts: start_blit during a fill -> ignored, no extra done. start_fill and start_blit in the same IDLE cycle -> fill runs. reset_n=0 at cycle 100 of a blit -> fb_we=0 immediately and no done pulse.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and geometry for the blitter and the color mapper.
// Pure declarations; no logic.
package fb_pkg;
   localparam int FB_W  = 640;
   localparam int FB_H  = 480;
   localparam int PIX_W = 5;
   localparam int FB_AW = 19;

   localparam logic [PIX_W-1:0] TRANSPARENT_IDX = 5'd0;

   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [FB_AW-1:0] fb_addr_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      BLIT,
      DRAIN,
      DONE
   } blit_state_t;

   // Row-major linear address; wide coordinates are kept intact until the bounds compare.
   function automatic fb_addr_t xy_to_addr(input logic [10:0] x, input logic [10:0] y, input int w);
      return fb_addr_t'(y) * fb_addr_t'(w) + fb_addr_t'(x);
   endfunction
endpackage

// File: rtl/fb_addr_calc.sv
// Combinational (x,y) -> frame buffer address plus visibility flag; zero latency.
// No handshake; shared with the color mapper.
module fb_addr_calc
   import fb_pkg::*;
#(
   parameter int FB_W = fb_pkg::FB_W,
   parameter int FB_H = fb_pkg::FB_H
)
(
   input  logic [10:0] i_x,
   input  logic [10:0] i_y,
   output fb_addr_t    o_addr,
   output logic        o_in_bounds
);
   localparam logic [10:0] W11 = 11'(FB_W);
   localparam logic [10:0] H11 = 11'(FB_H);

   assign o_addr      = xy_to_addr(i_x, i_y, FB_W);
   assign o_in_bounds = (i_x < W11) && (i_y < H11);
endmodule

// File: rtl/sprite_blitter.sv
// Writes sprites (with transparency and edge clipping) or a solid fill into the frame buffer.
// One pixel per clock, blit writes trail ROM addresses by 2 cycles; no backpressure accepted.
module sprite_blitter
   import fb_pkg::*;
#(
   parameter int FB_W  = fb_pkg::FB_W,
   parameter int FB_H  = fb_pkg::FB_H,
   parameter int SPR_W = 16,
   parameter int SPR_H = 16,
   parameter int ID_W  = 4,
   localparam int NPIX   = SPR_W * SPR_H,
   localparam int ROM_AW = ID_W + $clog2(NPIX)
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_blit,
   input  logic               start_fill,
   input  logic [ID_W-1:0]    sprite_id,
   input  logic [9:0]         pos_x,
   input  logic [9:0]         pos_y,
   input  logic [PIX_W-1:0]   fill_idx,
   output logic [ROM_AW-1:0]  rom_addr,
   input  logic [PIX_W-1:0]   rom_data,
   output logic [FB_AW-1:0]   fb_addr,
   output logic [PIX_W-1:0]   fb_data,
   output logic               fb_we,
   output logic               busy,
   output logic               done
);
   localparam int SX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int SY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam logic [SX_W-1:0] SX_LAST   = SX_W'(SPR_W - 1);
   localparam logic [SY_W-1:0] SY_LAST   = SY_W'(SPR_H - 1);
   localparam fb_addr_t        FILL_LAST = fb_addr_t'(FB_W * FB_H - 1);

   blit_state_t       r_state;
   logic [9:0]        r_pos_x;
   logic [9:0]        r_pos_y;
   logic [SX_W-1:0]   r_sx;
   logic [SY_W-1:0]   r_sy;
   logic              r_drain;
   logic              r_s2_vld;
   fb_addr_t          r_s2_addr;
   logic              r_s2_inb;
   logic [ROM_AW-1:0] r_rom_addr;
   fb_addr_t          r_fb_addr;
   pix_t              r_fb_data;
   logic              r_fb_we;
   logic              r_busy;
   logic              r_done;

   logic [10:0]       w_x;
   logic [10:0]       w_y;
   fb_addr_t          w_addr;
   logic              w_inb;
   logic              w_last;

   // 11-bit sums so a sprite hanging off the far edge never wraps back on screen.
   assign w_x    = {1'b0, r_pos_x} + 11'(r_sx);
   assign w_y    = {1'b0, r_pos_y} + 11'(r_sy);
   assign w_last = (r_sx == SX_LAST) && (r_sy == SY_LAST);

   fb_addr_calc #(
      .FB_W (FB_W),
      .FB_H (FB_H)
   ) u_addr_calc (
      .i_x         (w_x),
      .i_y         (w_y),
      .o_addr      (w_addr),
      .o_in_bounds (w_inb)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_pos_x    <= '0;
         r_pos_y    <= '0;
         r_sx       <= '0;
         r_sy       <= '0;
         r_drain    <= 1'b0;
         r_s2_vld   <= 1'b0;
         r_s2_addr  <= '0;
         r_s2_inb   <= 1'b0;
         r_rom_addr <= '0;
         r_fb_addr  <= '0;
         r_fb_data  <= '0;
         r_fb_we    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Write stage: rom_data now belongs to the pixel held in stage 2.
         if (r_s2_vld && (rom_data != TRANSPARENT_IDX) && r_s2_inb) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= r_s2_addr;
            r_fb_data <= rom_data;
         end else begin
            r_fb_we   <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (start_fill) begin
                  r_state   <= FILL;
                  r_busy    <= 1'b1;
                  r_fb_we   <= 1'b1;
                  r_fb_addr <= '0;
                  r_fb_data <= fill_idx;
               end else if (start_blit) begin
                  r_state    <= BLIT;
                  r_busy     <= 1'b1;
                  r_pos_x    <= pos_x;
                  r_pos_y    <= pos_y;
                  r_sx       <= '0;
                  r_sy       <= '0;
                  r_s2_vld   <= 1'b0;
                  r_rom_addr <= ROM_AW'(sprite_id) * ROM_AW'(NPIX);
               end
            end

            FILL: begin
               if (r_fb_addr == FILL_LAST) begin
                  r_state <= DONE;
                  r_fb_we <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_fb_we   <= 1'b1;
                  r_fb_addr <= r_fb_addr + 1'b1;
               end
            end

            BLIT: begin
               r_s2_vld  <= 1'b1;
               r_s2_addr <= w_addr;
               r_s2_inb  <= w_inb;
               if (w_last) begin
                  r_state <= DRAIN;
                  r_drain <= 1'b0;
               end else begin
                  r_rom_addr <= r_rom_addr + 1'b1;
                  if (r_sx == SX_LAST) begin
                     r_sx <= '0;
                     r_sy <= r_sy + 1'b1;
                  end else begin
                     r_sx <= r_sx + 1'b1;
                  end
               end
            end

            DRAIN: begin
               r_s2_vld <= 1'b0;
               r_drain  <= 1'b1;
               if (r_drain) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end

            DONE: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign rom_addr = r_rom_addr;
   assign fb_addr  = r_fb_addr;
   assign fb_data  = r_fb_data;
   assign fb_we    = r_fb_we;
   assign busy     = r_busy;
   assign done     = r_done;
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: table of blits, plus fill, restart and abort sequences.
// A short frame (96 rows) keeps the full fill within the cycle budget.
module tb_sprite_blitter;
   localparam int FBW  = 640;
   localparam int FBH  = 96;
   localparam int NPIX = 256;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_blit;
   logic        start_fill;
   logic [3:0]  sprite_id;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic [4:0]  fill_idx;
   logic [11:0] rom_addr;
   logic [4:0]  rom_data;
   logic [18:0] fb_addr;
   logic [4:0]  fb_data;
   logic        fb_we;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   sprite_blitter #(.FB_W(FBW), .FB_H(FBH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_blit (start_blit),
      .start_fill (start_fill),
      .sprite_id  (sprite_id),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .fill_idx   (fill_idx),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .fb_we      (fb_we),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {int cyc; int addr; int dat;} wr_t;
   typedef struct {int id; int x; int y; int n_wr; int first; int last;} vec_t;

   wr_t  sb[$];
   vec_t vecs[6];

   int n_vec = 0;
   int n_bad = 0;
   int edge_cnt = 0;
   int e0 = 0;
   int exp_done = 0;
   int exp_base = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int writes_seen = 0;
   int first_addr = -1;
   int last_addr = -1;
   bit mon_en = 1'b0;
   bit is_blit = 1'b0;

   // Sprite 3 has transparent even pixels; every other sprite is fully opaque.
   function automatic logic [4:0] rom_val(input int id, input int p);
      if (id == 3) return (p % 2 == 0) ? 5'd0 : 5'((p % 31) + 1);
      return 5'(((p + id * 7) % 31) + 1);
   endfunction

   always @(posedge clk) edge_cnt <= edge_cnt + 1;
   always @(posedge clk) rom_data <= rom_val(int'(rom_addr[11:8]), int'(rom_addr[7:0]));

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int n;
      wr_t w;
      if (mon_en) begin
         n = edge_cnt - e0;
         chk("busy", int'(busy), int'(n >= 1 && n < exp_done));
         if (is_blit && n >= 1 && n <= NPIX) chk("rom_addr", int'(rom_addr), exp_base + n - 1);
         if (done) begin
            done_cnt++;
            done_cyc = n;
         end
         if (fb_we) begin
            writes_seen++;
            if (first_addr < 0) first_addr = int'(fb_addr);
            last_addr = int'(fb_addr);
            if (sb.size() == 0) begin
               chk("unexpected_write_addr", int'(fb_addr), -1);
            end else begin
               w = sb.pop_front();
               chk("wr_addr", int'(fb_addr), w.addr);
               chk("wr_data", int'(fb_data), w.dat);
               chk("wr_cycle", n, w.cyc);
            end
         end
      end
   end

   task automatic arm(input bit f, input bit b, input int id, input int x, input int y, input int fi);
      start_fill = f;
      start_blit = b;
      sprite_id  = id[3:0];
      pos_x      = x[9:0];
      pos_y      = y[9:0];
      fill_idx   = fi[4:0];
      sb.delete();
      done_cnt = 0;
      done_cyc = -1;
      writes_seen = 0;
      first_addr = -1;
      last_addr = -1;
      e0 = edge_cnt;
      if (f) begin
         is_blit = 1'b0;
         exp_done = FBW * FBH + 1;
         for (int i = 0; i < FBW * FBH; i++) sb.push_back('{1 + i, i, fi});
      end else begin
         is_blit = 1'b1;
         exp_base = id * NPIX;
         exp_done = NPIX + 3;
         for (int sy = 0; sy < 16; sy++) begin
            for (int sx = 0; sx < 16; sx++) begin
               int p;
               int d;
               p = sy * 16 + sx;
               d = int'(rom_val(id, p));
               if (d != 0 && x + sx < FBW && y + sy < FBH)
                  sb.push_back('{3 + p, (y + sy) * FBW + x + sx, d});
            end
         end
      end
      mon_en = 1'b1;
      @(negedge clk); #1;
      start_fill = 1'b0;
      start_blit = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (done_cnt != 0) break;
         @(negedge clk); #1;
      end
      if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
   endtask

   task automatic post(input int n_wr, input int first, input int last, input int idle);
      repeat (idle) begin
         @(negedge clk); #1;
      end
      chk("done_cycle", done_cyc, exp_done);
      chk("done_pulses", done_cnt, 1);
      chk("write_count", writes_seen, n_wr);
      if (n_wr > 0) begin
         chk("first_addr", first_addr, first);
         chk("last_addr", last_addr, last);
      end
      chk("scoreboard_left", sb.size(), 0);
   endtask

   task automatic chk_idle_outs(input string nm);
      chk({nm, "_fb_we"}, int'(fb_we), 0);
      chk({nm, "_fb_addr"}, int'(fb_addr), 0);
      chk({nm, "_fb_data"}, int'(fb_data), 0);
      chk({nm, "_rom_addr"}, int'(rom_addr), 0);
      chk({nm, "_busy"}, int'(busy), 0);
      chk({nm, "_done"}, int'(done), 0);
   endtask

   initial begin
      vecs[0] = '{2, 100, 50, 256, 32100, 65 * 640 + 115};
      vecs[1] = '{3, 0, 0, 128, 1, 15 * 640 + 15};
      vecs[2] = '{1, 630, 86, 100, 86 * 640 + 630, 95 * 640 + 639};
      vecs[3] = '{1, 1023, 0, 0, -1, -1};
      vecs[4] = '{5, 0, 95, 16, 95 * 640, 95 * 640 + 15};
      vecs[5] = '{15, 624, 0, 256, 624, 15 * 640 + 639};

      // Reset held with random stimulus, then released with starts low.
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start_fill = 1'($urandom);
         start_blit = 1'($urandom);
         sprite_id  = 4'($urandom);
         pos_x      = 10'($urandom);
         pos_y      = 10'($urandom);
         fill_idx   = 5'($urandom);
         @(negedge clk); #1;
         chk_idle_outs("in_reset");
      end
      start_fill = 1'b0;
      start_blit = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk_idle_outs("after_reset");
      end

      for (int v = 0; v < 6; v++) begin
         arm(1'b0, 1'b1, vecs[v].id, vecs[v].x, vecs[v].y, 0);
         wait_done(400);
         post(vecs[v].n_wr, vecs[v].first, vecs[v].last, 3);
      end

      // Start in the DONE cycle is dropped; the next cycle's start is taken.
      arm(1'b0, 1'b1, 4, 10, 10, 0);
      wait_done(400);
      start_blit = 1'b1;
      sprite_id  = 4'd7;
      pos_x      = 10'd0;
      pos_y      = 10'd0;
      post(256, 10 * 640 + 10, 25 * 640 + 25, 0);
      @(negedge clk); #1;
      arm(1'b0, 1'b1, 6, 200, 30, 0);
      wait_done(400);
      post(256, 30 * 640 + 200, 45 * 640 + 215, 3);

      // Reset at cycle 100 of a blit aborts it with no further writes or done.
      arm(1'b0, 1'b1, 2, 100, 50, 0);
      repeat (99) begin
         @(negedge clk); #1;
      end
      mon_en = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("abort_fb_we_now", int'(fb_we), 0);
      chk("abort_busy_now", int'(busy), 0);
      sb.delete();
      for (int i = 0; i < 270; i++) begin
         @(negedge clk); #1;
         if (i == 3) reset_n = 1'b1;
         chk("abort_fb_we", int'(fb_we), 0);
         chk("abort_done", int'(done), 0);
      end

      // Fill wins over a simultaneous blit; a blit request mid-fill is ignored.
      arm(1'b1, 1'b1, 9, 5, 5, 3);
      repeat (98) begin
         @(negedge clk); #1;
      end
      start_blit = 1'b1;
      @(negedge clk); #1;
      start_blit = 1'b0;
      wait_done(FBW * FBH + 100);
      post(FBW * FBH, 0, FBW * FBH - 1, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
